// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   state_e    : transmitter FSM states
//   parity_e   : parity_type input encoding (00/11 none, 01 odd, 10 even)
//   char_len_e : char_len input encoding (00..11 = 5..8 data bits)
//   data_mask  : mask of the data bits actually sent for a given length
//   calc_parity: parity bit over the sent data bits only
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    LEN_5 = 2'b00,
    LEN_6 = 2'b01,
    LEN_7 = 2'b10,
    LEN_8 = 2'b11
  } char_len_e;

  function automatic logic parity_enabled(parity_e p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

  function automatic logic [7:0] data_mask(char_len_e len);
    return 8'hFF >> (2'd3 - len);
  endfunction

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic calc_parity(logic [7:0] data, char_len_e len, parity_e p);
    logic ones;
    ones = ^(data & data_mask(len));
    case (p)
      PAR_ODD:  return ~ones;
      PAR_EVEN: return ones;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Character write port of the buffered UART transmitter.
//   wr_valid : producer offers wr_data this cycle
//   wr_data  : 8-bit character, LSB sent first
//   wr_ready : transmitter FIFO can accept a character
interface uart_tx_buffered_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port.
//   clock, rst (sync, active-low)
//   wr_en/wr_data : write, ignored while full
//   rd_en/rd_data : pop, ignored while empty; rd_data updates the cycle after
//                   the pop edge and then holds until the next pop
//   count/full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A full FIFO refuses writes even when a pop happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
    if (rd_ok) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of characters feeding a frame serialiser
// with selectable baud rate, 5..8 data bits, none/odd/even parity, 1/2 stop
// bits and a line-break request.
//   clock, rst (sync, active-low)
//   wr_if                      : character write port (slave side)
//   baud_sel/parity_type/char_len/stop_bits : frame format, latched on pop
//   break_req                  : hold line low while high (taken only in idle)
//   data_out/parity_out        : serial line / parity bit of current frame
//   tx_active/tx_done          : busy flag / one-cycle end-of-frame pulse
//   fifo_count/full/empty      : FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD0       = 2400,
  parameter int BAUD1       = 4800,
  parameter int BAUD2       = 9600,
  parameter int BAUD3       = 19200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              clock,
  input  logic                              rst,
  uart_tx_buffered_if.slave                 wr_if,
  input  logic [1:0]                        baud_sel,
  input  logic [1:0]                        parity_type,
  input  logic [1:0]                        char_len,
  input  logic                              stop_bits,
  input  logic                              break_req,
  output logic                              data_out,
  output logic                              parity_out,
  output logic                              tx_active,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              fifo_full,
  output logic                              fifo_empty
);
  localparam int DIV0    = CLK_FREQ_HZ / BAUD0;
  localparam int DIV1    = CLK_FREQ_HZ / BAUD1;
  localparam int DIV2    = CLK_FREQ_HZ / BAUD2;
  localparam int DIV3    = CLK_FREQ_HZ / BAUD3;
  localparam int MAX01   = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int MAX23   = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int MAX_DIV = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       baud_q, baud_d;
  parity_e          par_q, par_d;
  char_len_e        len_q, len_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             pop;
  logic [7:0]       char_data;
  logic [CNT_W-1:0] div_m1;
  logic             tick;
  logic             parity_bit;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (wr_if.wr_valid),
    .wr_data (wr_if.wr_data),
    .rd_en   (pop),
    .rd_data (char_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_if.wr_ready = !fifo_full;

  always_comb begin
    case (baud_q)
      2'b00:   div_m1 = CNT_W'(DIV0 - 1);
      2'b01:   div_m1 = CNT_W'(DIV1 - 1);
      2'b10:   div_m1 = CNT_W'(DIV2 - 1);
      default: div_m1 = CNT_W'(DIV3 - 1);
    endcase
  end

  assign tick       = (cnt_q == div_m1);
  // The popped character stays in the FIFO read register for the whole frame.
  assign parity_bit = calc_parity(char_data, len_q, par_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    par_d     = par_q;
    len_d     = len_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (break_req) begin
          state_d = ST_BREAK;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          baud_d  = baud_sel;
          par_d   = parity_e'(parity_type);
          len_d   = char_len_e'(char_len);
          stop_d  = stop_bits;
        end
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == ({1'b0, len_q} + 3'd4))
            state_d = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
          else
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP: begin
        // bit_cnt counts stop bits already completed.
        if (tick) begin
          if (bit_cnt_q[0] == stop_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_BREAK: if (!break_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Every state entry restarts bit timing so each bit is a full period.
    if (state_d != state_q) begin
      cnt_d     = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      baud_q    <= 2'b00;
      par_q     <= PAR_NONE;
      len_q     <= LEN_5;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      par_q     <= par_d;
      len_q     <= len_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    data_out   = 1'b1;
    parity_out = 1'b0;
    case (state_q)
      ST_START:  data_out = 1'b0;
      ST_DATA:   data_out = char_data[bit_cnt_q];
      ST_PARITY: data_out = parity_bit;
      ST_BREAK:  data_out = 1'b0;
      default:   data_out = 1'b1;
    endcase
    if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
      parity_out = parity_bit;
  end

  assign tx_active = (state_q != ST_IDLE);
  assign tx_done   = done_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (96 kHz clock, DIV = 96000/baud).
// Writes push an expected frame into a queue; an independent line monitor
// detects start bits, pops the queue and compares the whole frame bit by bit.
module tb_uart_tx_buffered;
  localparam int CLK_HZ = 96000;
  localparam int DEPTH  = 8;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         ptype;   // 0 none, 1 odd, 2 even
    int         nstop;
    int         div;
  } frame_t;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] baud_sel = 2'b10;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] char_len = 2'b11;
  logic       stop_bits = 1'b0;
  logic       break_req = 1'b0;
  logic       data_out, parity_out, tx_active, tx_done, fifo_full, fifo_empty;
  logic [3:0] fifo_count;

  always #5 clock = ~clock;

  uart_tx_buffered_if wr_if ();

  uart_tx_buffered #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD0(2400), .BAUD1(4800), .BAUD2(9600), .BAUD3(19200),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .rst(rst), .wr_if(wr_if),
    .baud_sel(baud_sel), .parity_type(parity_type), .char_len(char_len),
    .stop_bits(stop_bits), .break_req(break_req),
    .data_out(data_out), .parity_out(parity_out), .tx_active(tx_active),
    .tx_done(tx_done), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
  );

  frame_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  done_count = 0;
  int  expected_done = 0;
  bit  mon_busy = 1'b0;
  bit  after_done = 1'b0;
  bit  gap_expected = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic frame_t make_frame(logic [7:0] d, int baud, int par, int len, int stp);
    frame_t f;
    f.data  = d;
    f.nbits = len + 5;
    f.ptype = (par == 1) ? 1 : (par == 2) ? 2 : 0;
    f.nstop = stp + 1;
    f.div   = CLK_HZ / (2400 << baud);
    return f;
  endfunction

  function automatic logic exp_parity(frame_t f);
    int ones = 0;
    for (int i = 0; i < f.nbits; i++) ones += int'(f.data[i]);
    if (f.ptype == 1) return (ones % 2 == 0);
    if (f.ptype == 2) return (ones % 2 == 1);
    return 1'b0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic run_frame(input frame_t f);
    logic       bits[$];
    logic       par;
    logic       bad;
    logic [3:0] got;
    bit         aborted;
    mon_busy = 1'b1;
    par = exp_parity(f);
    bits.push_back(1'b0);
    for (int i = 0; i < f.nbits; i++) bits.push_back(f.data[i]);
    if (f.ptype != 0) bits.push_back(par);
    for (int i = 0; i < f.nstop; i++) bits.push_back(1'b1);
    aborted = 1'b0;
    for (int b = 0; b < bits.size() && !aborted; b++) begin
      bad = 1'b0;
      got = '0;
      for (int c = 0; c < f.div && !aborted; c++) begin
        if (b != 0 || c != 0) @(negedge clock);
        if (!rst) aborted = 1'b1;
        else if (!bad && (data_out !== bits[b] || parity_out !== par ||
                          tx_active !== 1'b1 || tx_done !== 1'b0)) begin
          bad = 1'b1;
          got = {data_out, parity_out, tx_active, tx_done};
        end
      end
      if (!aborted) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame_bit: data=%02h bit %0d got line,parity_out,active,done=%b required %b%b10",
                   f.data, b, got, bits[b], par);
        end
      end
    end
    if (!aborted) begin
      @(negedge clock);
      if (rst) begin
        check("done_pulse", {29'd0, tx_done, data_out, tx_active}, 32'b110);
        after_done   = 1'b1;
        gap_expected = (exp_q.size() > 0) && !break_req;
      end
    end
    mon_busy = 1'b0;
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!rst) begin
        prev = 1'b1;
        after_done = 1'b0;
        gap_expected = 1'b0;
      end else begin
        if (after_done) begin
          check("done_width", tx_done, 1'b0);
          if (gap_expected) check("gap_one_idle", data_out, 1'b0);
          after_done = 1'b0;
          gap_expected = 1'b0;
        end
        if (prev && !data_out && !break_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got start bit at %0t required idle line", $time);
            prev = 1'b0;
          end else begin
            run_frame(exp_q.pop_front());
            prev = data_out;
          end
        end else begin
          prev = data_out;
        end
      end
    end
  end

  always @(negedge clock) if (rst && tx_done) done_count++;

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic apply_cfg(input int baud, input int par, input int len, input int stp);
    baud_sel    = 2'(baud);
    parity_type = 2'(par);
    char_len    = 2'(len);
    stop_bits   = 1'(stp);
  endtask

  task automatic write_word(input frame_t f, input logic exp_ready);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = f.data;
    @(negedge clock);
    check("wr_ready", wr_if.wr_ready, exp_ready);
    @(posedge clock);
    #1;
    wr_if.wr_valid = 1'b0;
    if (exp_ready) begin
      exp_q.push_back(f);
      expected_done++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_active) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic measure_done(input string name, input int req_cycles);
    int n = 0;
    while (data_out && n < 10) begin
      @(negedge clock);
      n++;
    end
    n = 1;
    while (!tx_done && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(name, n, req_cycles);
  endtask

  initial begin : stimulus
    frame_t fa, fb;
    int     d0;
    logic   line_bad;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data_out", data_out, 1'b1);
    check("rst_parity_out", parity_out, 1'b0);
    check("rst_tx_active", tx_active, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_fifo_count", fifo_count, 4'd0);
    check("rst_fifo_empty", fifo_empty, 1'b1);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_wr_ready", wr_if.wr_ready, 1'b1);
    @(posedge clock);
    #1 rst = 1'b1;
    @(posedge clock);
    #1;

    // 0x55, 8 bits, odd parity, one stop at DIV=10
    apply_cfg(2, 1, 3, 0);
    write_word(make_frame(8'h55, 2, 1, 3, 0), 1'b1);
    @(negedge clock);
    check("no_same_cycle_pop", data_out, 1'b1);
    @(negedge clock);
    check("start_latency", data_out, 1'b0);
    check("parity_out_55", parity_out, 1'b1);
    measure_done("done_cycle_55", 111);
    wait_idle(300);

    // 0x1F, 5 bits, even parity, two stop
    apply_cfg(2, 2, 0, 1);
    write_word(make_frame(8'h1F, 2, 2, 0, 1), 1'b1);
    measure_done("done_cycle_1f", 91);
    wait_idle(300);

    // Two queued words: one idle cycle between frames, two done pulses
    apply_cfg(3, 0, 3, 0);
    d0 = done_count;
    write_word(make_frame(8'hC3, 3, 0, 3, 0), 1'b1);
    write_word(make_frame(8'h3A, 3, 0, 3, 0), 1'b1);
    wait_idle(400);
    check("two_done_pulses", done_count - d0, 2);

    // Format change mid-frame applies only from the next pop
    apply_cfg(2, 1, 3, 0);
    write_word(make_frame(8'hA5, 2, 1, 3, 0), 1'b1);
    write_word(make_frame(8'h3C, 3, 2, 2, 1), 1'b1);
    @(negedge clock);
    check("active_after_pop", tx_active, 1'b1);
    @(posedge clock);
    #1 apply_cfg(3, 2, 2, 1);
    wait_idle(400);

    // Break while filling the FIFO past its depth
    apply_cfg(3, 0, 3, 0);
    break_req = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("break_line_low", data_out, 1'b0);
    check("break_active", tx_active, 1'b1);
    @(posedge clock);
    #1;
    line_bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      write_word(make_frame(8'($urandom), 3, 0, 3, 0), (k < DEPTH) ? 1'b1 : 1'b0);
      @(negedge clock);
      check("break_fifo_count", fifo_count, (k < DEPTH) ? k + 1 : DEPTH);
      if (data_out !== 1'b0) line_bad = 1'b1;
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("break_full", fifo_full, 1'b1);
    check("break_wr_ready", wr_if.wr_ready, 1'b0);
    check("break_empty", fifo_empty, 1'b0);
    check("break_line_held", line_bad, 1'b0);
    @(posedge clock);
    #1 break_req = 1'b0;
    wait_idle(1000);

    // Reset during the third data bit
    apply_cfg(2, 0, 3, 0);
    fa = make_frame(8'hF0, 2, 0, 3, 0);
    fb = make_frame(8'h0F, 2, 0, 3, 0);
    write_word(fa, 1'b1);
    begin
      int n = 0;
      while (data_out && n < 10) begin
        @(negedge clock);
        n++;
      end
      check("rst_test_start", data_out, 1'b0);
    end
    @(posedge clock);
    #1;
    write_word(fb, 1'b1);
    repeat (30) @(negedge clock);
    @(posedge clock);
    #1 rst = 1'b0;
    exp_q.delete();
    expected_done -= 2;
    d0 = done_count;
    @(posedge clock);
    @(negedge clock);
    check("midrst_data_out", data_out, 1'b1);
    check("midrst_tx_active", tx_active, 1'b0);
    check("midrst_fifo_count", fifo_count, 4'd0);
    check("midrst_tx_done", tx_done, 1'b0);
    @(posedge clock);
    #1 rst = 1'b1;
    line_bad = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_out !== 1'b1 || tx_done !== 1'b0) line_bad = 1'b1;
    end
    check("midrst_line_idle", line_bad, 1'b0);
    check("midrst_no_done", done_count - d0, 0);
    @(posedge clock);
    #1;

    // Randomised bursts with random formats
    for (int burst = 0; burst < 6; burst++) begin
      int b, p, l, s, nw;
      b  = $urandom_range(1, 3);
      p  = $urandom_range(0, 3);
      l  = $urandom_range(0, 3);
      s  = $urandom_range(0, 1);
      nw = $urandom_range(1, 3);
      apply_cfg(b, p, l, s);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 15)) @(posedge clock);
        #1;
        write_word(make_frame(8'($urandom), b, p, l, s), 1'b1);
      end
      wait_idle(1500);
    end

    check("done_total", done_count, expected_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
